// File: rtl/hdmi_aux_receiver.sv
// Slot-serial HDMI data-island aux packet receiver: reassembles header and
// subpacket 0 over slots 0..31 and decodes audio sample and clock regen packets.
module hdmi_aux_receiver (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ae_i,
  input  logic [4:0]  aux_slot_i,
  input  logic        header_i,
  input  logic [1:0]  sub0_i,
  output logic [15:0] sample_left_o,
  output logic [15:0] sample_right_o,
  output logic        sample_valid_o,
  output logic        parity_error_o,
  output logic [19:0] cts_o,
  output logic [19:0] n_o,
  output logic        regen_valid_o,
  output logic [31:0] cs_word_o,
  output logic        cs_valid_o,
  output logic        packet_error_o
);

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [4:0]  expected_q, expected_d;
  logic [31:0] hdr_q, hdr_d, hdr_cap_s;
  logic [63:0] sb_q, sb_d, sb_cap_s;
  logic [15:0] sample_left_q, sample_left_d, sample_right_q, sample_right_d;
  logic        sample_valid_q, sample_valid_d, parity_error_q, parity_error_d;
  logic [19:0] cts_q, cts_d, n_q, n_d;
  logic        regen_valid_q, regen_valid_d;
  logic [31:0] cs_word_q, cs_word_d, cs_shift_q, cs_shift_d;
  logic        cs_valid_q, cs_valid_d, packet_error_q, packet_error_d;
  logic [7:0]  frame_idx_q, frame_idx_d;
  logic        cs_locked_q, cs_locked_d;
  logic        capture_s, eval_s;

  // The packet image as it will look once the current slot is written, so
  // slot 31 is evaluated in the cycle that delivers it.
  always_comb begin
    hdr_cap_s = hdr_q;
    sb_cap_s  = sb_q;
    hdr_cap_s[aux_slot_i]             = header_i;
    sb_cap_s[{aux_slot_i, 1'b0} +: 2] = sub0_i;
  end

  always_comb begin
    state_d        = state_q;
    expected_d     = expected_q;
    hdr_d          = hdr_q;
    sb_d           = sb_q;
    sample_left_d  = sample_left_q;
    sample_right_d = sample_right_q;
    cts_d          = cts_q;
    n_d            = n_q;
    cs_word_d      = cs_word_q;
    cs_shift_d     = cs_shift_q;
    frame_idx_d    = frame_idx_q;
    cs_locked_d    = cs_locked_q;
    sample_valid_d = 1'b0;
    parity_error_d = 1'b0;
    regen_valid_d  = 1'b0;
    cs_valid_d     = 1'b0;
    packet_error_d = 1'b0;
    capture_s      = 1'b0;
    eval_s         = 1'b0;

    case (state_q)
      IDLE: begin
        if (ae_i && (aux_slot_i == 5'd0)) begin
          capture_s  = 1'b1;
          expected_d = 5'd1;
          state_d    = COLLECT;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (!ae_i) begin
          state_d = COLLECT;
        end else if (aux_slot_i == expected_q) begin
          capture_s  = 1'b1;
          expected_d = expected_q + 5'd1;
          if (aux_slot_i == 5'd31) begin
            eval_s     = 1'b1;
            expected_d = 5'd0;
            state_d    = IDLE;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          packet_error_d = 1'b1;
          // A fresh slot 0 doubles as the start of the next packet.
          if (aux_slot_i == 5'd0) begin
            capture_s  = 1'b1;
            expected_d = 5'd1;
            state_d    = COLLECT;
          end else begin
            expected_d = 5'd0;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        expected_d = 5'd0;
      end
    endcase

    if (capture_s) begin
      hdr_d = hdr_cap_s;
      sb_d  = sb_cap_s;
    end else begin
      hdr_d = hdr_q;
      sb_d  = sb_q;
    end

    if (eval_s) begin
      case (hdr_cap_s[7:0])
        8'h02: begin
          sample_left_d  = sb_cap_s[23:8];
          sample_right_d = sb_cap_s[47:32];
          sample_valid_d = 1'b1;
          parity_error_d = ((^sb_cap_s[23:8]) != sb_cap_s[51]) ||
                           ((^sb_cap_s[47:32]) != sb_cap_s[55]);
          if (hdr_cap_s[20]) begin
            frame_idx_d = 8'd0;
            cs_locked_d = 1'b1;
          end else if (frame_idx_q < 8'd192) begin
            frame_idx_d = frame_idx_q + 8'd1;
          end else begin
            frame_idx_d = 8'd192;
          end
          if (cs_locked_d && (frame_idx_d < 8'd32)) begin
            cs_shift_d[frame_idx_d[4:0]] = sb_cap_s[50];
          end else begin
            cs_shift_d = cs_shift_q;
          end
          if (cs_locked_d && (frame_idx_d == 8'd31)) begin
            cs_word_d  = cs_shift_d;
            cs_valid_d = 1'b1;
          end else begin
            cs_word_d = cs_word_q;
          end
        end
        8'h01: begin
          cts_d         = {sb_cap_s[11:8], sb_cap_s[23:16], sb_cap_s[31:24]};
          n_d           = {sb_cap_s[35:32], sb_cap_s[47:40], sb_cap_s[55:48]};
          regen_valid_d = 1'b1;
        end
        default: begin
          sample_valid_d = 1'b0;
        end
      endcase
    end else begin
      cs_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      expected_q     <= 5'd0;
      hdr_q          <= 32'd0;
      sb_q           <= 64'd0;
      sample_left_q  <= 16'd0;
      sample_right_q <= 16'd0;
      sample_valid_q <= 1'b0;
      parity_error_q <= 1'b0;
      cts_q          <= 20'd0;
      n_q            <= 20'd0;
      regen_valid_q  <= 1'b0;
      cs_word_q      <= 32'd0;
      cs_shift_q     <= 32'd0;
      cs_valid_q     <= 1'b0;
      packet_error_q <= 1'b0;
      frame_idx_q    <= 8'd0;
      cs_locked_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      expected_q     <= expected_d;
      hdr_q          <= hdr_d;
      sb_q           <= sb_d;
      sample_left_q  <= sample_left_d;
      sample_right_q <= sample_right_d;
      sample_valid_q <= sample_valid_d;
      parity_error_q <= parity_error_d;
      cts_q          <= cts_d;
      n_q            <= n_d;
      regen_valid_q  <= regen_valid_d;
      cs_word_q      <= cs_word_d;
      cs_shift_q     <= cs_shift_d;
      cs_valid_q     <= cs_valid_d;
      packet_error_q <= packet_error_d;
      frame_idx_q    <= frame_idx_d;
      cs_locked_q    <= cs_locked_d;
    end
  end

  assign sample_left_o  = sample_left_q;
  assign sample_right_o = sample_right_q;
  assign sample_valid_o = sample_valid_q;
  assign parity_error_o = parity_error_q;
  assign cts_o          = cts_q;
  assign n_o            = n_q;
  assign regen_valid_o  = regen_valid_q;
  assign cs_word_o      = cs_word_q;
  assign cs_valid_o     = cs_valid_q;
  assign packet_error_o = packet_error_q;

endmodule

// File: tb/tb_hdmi_aux_receiver.sv
// Directed bench for hdmi_aux_receiver: table of whole packets plus
// hand-written slot-sequence, channel-status and reset sequences.
module tb_hdmi_aux_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ae = 1'b0;
  logic [4:0]  aux_slot = 5'd0;
  logic        header = 1'b0;
  logic [1:0]  sub0 = 2'b00;
  logic [15:0] sample_left, sample_right;
  logic        sample_valid, parity_error, regen_valid, cs_valid, packet_error;
  logic [19:0] cts, n;
  logic [31:0] cs_word;

  int total = 0;
  int bad = 0;
  int c_sv = 0, c_pe = 0, c_rv = 0, c_cv = 0, c_ke = 0;

  hdmi_aux_receiver dut (
    .clk_i(clk), .reset_i(reset), .ae_i(ae), .aux_slot_i(aux_slot),
    .header_i(header), .sub0_i(sub0),
    .sample_left_o(sample_left), .sample_right_o(sample_right),
    .sample_valid_o(sample_valid), .parity_error_o(parity_error),
    .cts_o(cts), .n_o(n), .regen_valid_o(regen_valid),
    .cs_word_o(cs_word), .cs_valid_o(cs_valid), .packet_error_o(packet_error)
  );

  always #5 clk = ~clk;

  // Pulse counters; a pulse held two cycles counts twice.
  always @(negedge clk) begin
    if (sample_valid) c_sv++;
    if (parity_error) c_pe++;
    if (regen_valid)  c_rv++;
    if (cs_valid)     c_cv++;
    if (packet_error) c_ke++;
  end

  typedef struct {
    logic [31:0] hdr;
    logic [63:0] sb;
    int          d_sv, d_pe, d_rv;
    logic [15:0] l, r;
    logic [19:0] cts, n;
  } vec_t;

  vec_t tv[7];

  function automatic logic [63:0] mk_audio(input logic [15:0] l, input logic [15:0] r,
                                           input logic pl, input logic pr, input logic cl);
    logic [63:0] s;
    s = 64'd0;
    s[23:8]  = l;
    s[47:32] = r;
    s[50]    = cl;
    s[51]    = pl;
    s[55]    = pr;
    return s;
  endfunction

  function automatic logic [63:0] mk_regen(input logic [19:0] c, input logic [19:0] nn);
    logic [63:0] s;
    s = 64'd0;
    s[11:8]  = c[19:16];
    s[23:16] = c[15:8];
    s[31:24] = c[7:0];
    s[35:32] = nn[19:16];
    s[47:40] = nn[15:8];
    s[55:48] = nn[7:0];
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_slot(input logic [4:0] s, input logic [31:0] h, input logic [63:0] sb);
    @(negedge clk);
    ae       = 1'b1;
    aux_slot = s;
    header   = h[s];
    sub0     = sb[{s, 1'b0} +: 2];
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      ae = 1'b0;
    end
  endtask

  task automatic send_pkt(input logic [31:0] h, input logic [63:0] sb, input bit gap_after);
    for (int s = 0; s < 32; s++) send_slot(5'(s), h, sb);
    if (gap_after) idle(1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " left"}, 64'(sample_left), 64'd0);
    chk({tag, " right"}, 64'(sample_right), 64'd0);
    chk({tag, " cts"}, 64'(cts), 64'd0);
    chk({tag, " n"}, 64'(n), 64'd0);
    chk({tag, " cs_word"}, 64'(cs_word), 64'd0);
    chk({tag, " pulses"}, 64'({sample_valid, parity_error, regen_valid, cs_valid, packet_error}), 64'd0);
  endtask

  initial begin
    int b_sv, b_pe, b_rv, b_cv, b_ke;
    logic [31:0] pat;

    tv[0] = '{32'h0000_0002, mk_audio(16'h1234, 16'hBEEF, 1'b1, 1'b1, 1'b0), 1, 0, 0,
              16'h1234, 16'hBEEF, 20'h0, 20'h0};
    tv[1] = '{32'h0000_0002, mk_audio(16'h1234, 16'hBEEF, 1'b1, 1'b0, 1'b0), 1, 1, 0,
              16'h1234, 16'hBEEF, 20'h0, 20'h0};
    tv[2] = '{32'h0000_0001, 64'h0000_1000_00FA_0000, 0, 0, 1,
              16'h1234, 16'hBEEF, 20'h0FA00, 20'h01000};
    tv[3] = '{32'h0000_0005, mk_audio(16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0), 0, 0, 0,
              16'h1234, 16'hBEEF, 20'h0FA00, 20'h01000};
    tv[4] = '{32'h0000_0002, mk_audio(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0), 1, 1, 0,
              16'h0001, 16'h0000, 20'h0FA00, 20'h01000};
    tv[5] = '{32'h5AAB_CD02, mk_audio(16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b0), 1, 0, 0,
              16'hFFFF, 16'h8000, 20'h0FA00, 20'h01000};
    tv[6] = '{32'h0000_0001, mk_regen(20'h12345, 20'h6789A), 0, 0, 1,
              16'hFFFF, 16'h8000, 20'h12345, 20'h6789A};

    idle(3);
    chk_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    for (int i = 0; i < 7; i++) begin
      b_sv = c_sv; b_pe = c_pe; b_rv = c_rv;
      send_pkt(tv[i].hdr, tv[i].sb, 1'b1);
      idle(2);
      chk($sformatf("v%0d sample_valid", i), 64'(c_sv - b_sv), 64'(tv[i].d_sv));
      chk($sformatf("v%0d parity_error", i), 64'(c_pe - b_pe), 64'(tv[i].d_pe));
      chk($sformatf("v%0d regen_valid", i), 64'(c_rv - b_rv), 64'(tv[i].d_rv));
      chk($sformatf("v%0d left", i), 64'(sample_left), 64'(tv[i].l));
      chk($sformatf("v%0d right", i), 64'(sample_right), 64'(tv[i].r));
      chk($sformatf("v%0d cts", i), 64'(cts), 64'(tv[i].cts));
      chk($sformatf("v%0d n", i), 64'(n), 64'(tv[i].n));
    end
    chk("no cs before B.0", 64'(c_cv), 64'd0);
    chk("no seq error in table", 64'(c_ke), 64'd0);

    // Slots 0..9 then 11, then a clean packet with a gap before slot 12.
    b_sv = c_sv; b_ke = c_ke;
    for (int s = 0; s < 10; s++) send_slot(5'(s), 32'h2, mk_audio(16'h1111, 16'h2222, 1'b1, 1'b1, 1'b0));
    send_slot(5'd11, 32'h2, 64'd0);
    idle(2);
    chk("seq err pulse", 64'(c_ke - b_ke), 64'd1);
    chk("seq err no sample", 64'(c_sv - b_sv), 64'd0);
    for (int s = 0; s < 32; s++) begin
      if (s == 12) idle(3);
      send_slot(5'(s), 32'h2, mk_audio(16'h0F0F, 16'h00FF, 1'b0, 1'b0, 1'b0));
    end
    idle(2);
    chk("after err sample", 64'(c_sv - b_sv), 64'd1);
    chk("after err left", 64'(sample_left), 64'h0F0F);
    chk("after err right", 64'(sample_right), 64'h00FF);
    chk("gap no seq err", 64'(c_ke - b_ke), 64'd1);

    // Restart: slot 0 in mid-packet begins a new packet.
    b_sv = c_sv; b_ke = c_ke; b_pe = c_pe;
    for (int s = 0; s < 6; s++) send_slot(5'(s), 32'h1, 64'd0);
    send_pkt(32'h2, mk_audio(16'hC001, 16'h7001, 1'b0, 1'b1, 1'b0), 1'b1);
    idle(2);
    chk("restart seq err", 64'(c_ke - b_ke), 64'd1);
    chk("restart sample", 64'(c_sv - b_sv), 64'd1);
    chk("restart left", 64'(sample_left), 64'hC001);
    chk("restart parity", 64'(c_pe - b_pe), 64'd1);

    // Channel status: two blocks of back-to-back audio packets.
    pat = 32'h0300_4004;
    b_sv = c_sv; b_cv = c_cv;
    for (int f = 0; f < 192; f++) begin
      send_pkt((f == 0) ? 32'h0010_0002 : 32'h0000_0002,
               mk_audio(16'(f), 16'(f * 3), ^16'(f), ^16'(f * 3), pat[f % 32]), 1'b0);
      if (f == 30) begin
        @(negedge clk);
        chk("cs before frame 31", 64'(c_cv - b_cv), 64'd0);
      end
    end
    idle(3);
    chk("cs block1 count", 64'(c_cv - b_cv), 64'd1);
    chk("cs block1 word", 64'(cs_word), 64'h0300_4004);
    chk("b2b sample count", 64'(c_sv - b_sv), 64'd192);
    chk("b2b last left", 64'(sample_left), 64'd191);
    pat = 32'hA5A5_0F0F;
    b_cv = c_cv;
    for (int f = 0; f < 40; f++)
      send_pkt((f == 0) ? 32'h0010_0002 : 32'h0000_0002,
               mk_audio(16'h0, 16'h0, 1'b0, 1'b0, pat[f % 32]), 1'b0);
    idle(3);
    chk("cs block2 count", 64'(c_cv - b_cv), 64'd1);
    chk("cs block2 word", 64'(cs_word), 64'hA5A5_0F0F);

    // Reset at slot 15 of a packet, then the tail of that packet.
    b_sv = c_sv; b_rv = c_rv; b_ke = c_ke; b_pe = c_pe; b_cv = c_cv;
    for (int s = 0; s < 16; s++) send_slot(5'(s), 32'h2, mk_audio(16'h5A5A, 16'hA5A5, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    ae = 1'b0;
    reset = 1'b1;
    idle(2);
    chk_outputs_zero("in reset");
    @(negedge clk);
    reset = 1'b0;
    for (int s = 16; s < 32; s++) send_slot(5'(s), 32'h2, mk_audio(16'h5A5A, 16'hA5A5, 1'b0, 1'b0, 1'b0));
    idle(3);
    chk_outputs_zero("after reset tail");
    chk("reset no pulses", 64'((c_sv - b_sv) + (c_rv - b_rv) + (c_ke - b_ke) + (c_pe - b_pe) + (c_cv - b_cv)), 64'd0);
    send_pkt(32'h2, mk_audio(16'h4321, 16'h8765, 1'b1, 1'b0, 1'b0), 1'b1);
    idle(2);
    chk("post reset sample", 64'(c_sv - b_sv), 64'd1);
    chk("post reset left", 64'(sample_left), 64'h4321);
    chk("post reset right", 64'(sample_right), 64'h8765);
    chk("post reset parity", 64'(c_pe - b_pe), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
